ascon_out_buffer: RTL and testbench
===================================

// Module: ascon_out_buffer
// PURPOSE
//  Parametrised output buffer for the ASCON datapath: queues cipher words from the permutation core and holds the final tag.
//  Generalises the single enabled capture register into a depth_g-entry FIFO with a valid/ready drain port and a separate tag slot.
//  The tag is released only after every cipher word of the frame has drained.
//  Sits between the ASCON FSM/permutation and the host interface.
// PARAMETERS
//  nb_bits_g   64   width of one cipher word (data_i/data_o)
//  depth_g     4    number of cipher-word entries; >=2, need not be a power of two
//  tag_bits_g  128  width of tag_i/tag_o
// PORTS
//  clock_i       in   1                     single clock, rising edge
//  resetb_i      in   1                     reset, synchronous, active-low
//  clear_i       in   1                     synchronous flush of FIFO, tag slot and overflow flag
//  wr_en_i       in   1                     push data_i this cycle
//  data_i        in   nb_bits_g             cipher word to push
//  data_valid_o  out  1                     data_o holds the oldest queued word
//  data_ready_i  in   1                     consumer accepts data_o (pop when data_valid_o=1)
//  data_o        out  nb_bits_g             oldest queued word
//  tag_en_i      in   1                     capture tag_i into the tag slot
//  tag_i         in   tag_bits_g            tag to capture
//  tag_valid_o   out  1                     tag_o valid: tag pending AND FIFO empty
//  tag_ack_i     in   1                     consumer takes the tag (effective when tag_valid_o=1)
//  tag_o         out  tag_bits_g            captured tag
//  count_o       out  $clog2(depth_g+1)     number of queued words
//  full_o        out  1                     count_o == depth_g
//  empty_o       out  1                     count_o == 0
//  overflow_o    out  1                     sticky: write dropped or tag overwritten
// BEHAVIOUR
//  - All state updates on posedge clock_i. Priority order: resetb_i=0, then clear_i, then normal operation.
//  - Reset and clear values: count 0, read/write pointers 0, tag_pending 0, overflow_o 0.
//    data_o=0, tag_o=0, data_valid_o=0, tag_valid_o=0, empty_o=1, full_o=0.
//    Storage contents are not cleared; data_o is forced to 0 while the FIFO is empty.
//  - Pop: occurs when data_valid_o && data_ready_i. The read pointer advances and wraps from depth_g-1 to 0.
//  - Push: accepted when wr_en_i && (!full_o || pop in the same cycle). The word is written at the write pointer, which wraps the same way.
//  - Push while full without a pop: the word is dropped, overflow_o is set, and the FIFO is unchanged.
//  - Simultaneous push and pop: count_o is unchanged and both pointers advance.
//  - Push to an empty FIFO: data_valid_o rises the next cycle (latency 1).
//    No same-cycle fall-through: a pop requires data_valid_o=1 at the start of the cycle.
//  - data_o, data_valid_o, count_o, full_o and empty_o are registered/derived from registered state. No combinational path from inputs.
//  - Tag capture: tag_en_i && !tag_pending loads tag_o and sets tag_pending.
//    tag_en_i while tag_pending with no ack that cycle: tag_o is overwritten and overflow_o is set.
//  - tag_valid_o = tag_pending && empty_o, with empty_o taken after the cycle's pop.
//    The tag therefore follows the last word by at least 1 cycle.
//  - Tag release: tag_ack_i && tag_valid_o clears tag_pending; tag_valid_o falls the next cycle.
//    tag_o holds its value until the next capture.
//    tag_ack_i while tag_valid_o=0 is ignored.
//  - Ack and tag_en_i in the same cycle: the ack takes effect and the new tag loads.
//    tag_pending stays 1 and overflow_o is not set.
//  - Tag and word traffic are independent: words may be pushed while a tag is pending.
//    Those words must drain before the tag becomes valid again.
//  - overflow_o clears only on reset or clear_i.
//  - clear_i mid-frame discards all words and the pending tag within the same cycle. Any push or tag_en_i in that cycle is ignored.
// TESTING
//  1. Reset with resetb_i=0 for 2 cycles -> count_o=0, empty_o=1, data_valid_o=0, tag_valid_o=0, overflow_o=0, data_o=0.
//  2. Push 0x11..0x44 (depth 4) with data_ready_i=0 -> full_o=1, count_o=4.
//     Then ready=1 -> data_o reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then empty_o=1.
//  3. Full FIFO, push 0x55 with no pop -> overflow_o=1, count_o=4, 0x55 never output.
//     Full FIFO, push and pop together -> count_o stays 4 and order is preserved across pointer wrap.
//  4. Push 2 words, tag_en_i with tag 0xA5A5...A5 -> tag_valid_o=0 until both words have popped.
//     tag_valid_o=1 one cycle after the last pop; tag_ack_i -> tag_valid_o=0 the next cycle.
//  5. Second tag_en_i while the tag is pending and unacked -> tag_o holds the new tag and overflow_o=1.
//     Ack and new tag in the same cycle -> tag_valid_o stays 1 and overflow_o stays 0.
//  6. clear_i with 3 words and a pending tag (plus wr_en_i the same cycle) -> next cycle count_o=0, tag_valid_o=0, overflow_o=0.
//     Reset asserted mid-drain -> same values as scenario 1.

Source files
------------

// File: rtl/ascon_out_buffer.sv
// -----------------------------------------------------------------------------
// ascon_out_buffer
//
// Output buffer between the ASCON FSM/permutation core and the host interface.
// Cipher words are queued in a depth_g-entry FIFO and drained through a
// valid/ready port. The final tag sits in its own slot. It is offered to the
// host only once every queued cipher word of the frame has drained.
//
// Ports
//   clock_i       in   single clock, rising edge
//   resetb_i      in   synchronous reset, active-low
//   clear_i       in   synchronous flush of FIFO, tag slot and overflow flag
//   wr_en_i       in   push data_i this cycle
//   data_i        in   cipher word to push
//   data_valid_o  out  data_o holds the oldest queued word
//   data_ready_i  in   consumer accepts data_o (pop when data_valid_o=1)
//   data_o        out  oldest queued word (0 while empty)
//   tag_en_i      in   capture tag_i into the tag slot
//   tag_i         in   tag to capture
//   tag_valid_o   out  tag pending and FIFO empty
//   tag_ack_i     in   consumer takes the tag (effective when tag_valid_o=1)
//   tag_o         out  captured tag
//   count_o       out  number of queued words
//   full_o        out  count_o == depth_g
//   empty_o       out  count_o == 0
//   overflow_o    out  sticky: word dropped or pending tag overwritten
// -----------------------------------------------------------------------------
module ascon_out_buffer #(
    parameter int nb_bits_g  = 64,
    parameter int depth_g    = 4,
    parameter int tag_bits_g = 128,
    localparam int cnt_w     = $clog2(depth_g + 1),
    localparam int ptr_w     = $clog2(depth_g)
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [nb_bits_g-1:0]  data_i,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic [nb_bits_g-1:0]  data_o,
    input  logic                  tag_en_i,
    input  logic [tag_bits_g-1:0] tag_i,
    output logic                  tag_valid_o,
    input  logic                  tag_ack_i,
    output logic [tag_bits_g-1:0] tag_o,
    output logic [cnt_w-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o
);

    logic [nb_bits_g-1:0]  mem [depth_g];

    logic [ptr_w-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [ptr_w-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [cnt_w-1:0]      count_reg, count_next;
    logic [nb_bits_g-1:0]  data_reg;
    logic [tag_bits_g-1:0] tag_reg;
    logic                  tag_pending_reg, tag_pending_next;
    logic                  overflow_reg, overflow_next;

    logic                  fifo_empty, fifo_full;
    logic                  pop, push, drop, tag_ack;

    // Pointers wrap at depth_g, which need not be a power of two.
    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth_g - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        fifo_empty       = (count_reg == '0);
        fifo_full        = (count_reg == cnt_w'(depth_g));
        pop              = !fifo_empty && data_ready_i;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push             = wr_en_i && (!fifo_full || pop);
        drop             = wr_en_i && fifo_full && !pop;
        rd_ptr_next      = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        wr_ptr_next      = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;

        count_next       = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end

        // The tag is only visible (and so only ackable) once the FIFO is empty.
        tag_ack          = tag_ack_i && tag_pending_reg && fifo_empty;
        tag_pending_next = tag_pending_reg;
        if (tag_en_i) begin
            tag_pending_next = 1'b1;
        end else if (tag_ack) begin
            tag_pending_next = 1'b0;
        end

        // Overwriting a pending tag is only an error if it was not taken
        // in the same cycle.
        overflow_next    = overflow_reg | drop | (tag_en_i && tag_pending_reg && !tag_ack);
    end

    // Storage is never reset so it can map onto RAM.
    always_ff @(posedge clock_i) begin
        if (resetb_i && !clear_i && push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i || clear_i) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            data_reg        <= '0;
            tag_reg         <= '0;
            tag_pending_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            count_reg       <= count_next;
            tag_pending_reg <= tag_pending_next;
            overflow_reg    <= overflow_next;
            if (tag_en_i) begin
                tag_reg <= tag_i;
            end
            // Registered head-of-queue read. When the word being written this
            // cycle becomes the new head, the RAM still holds stale data, so
            // bypass data_i directly.
            if (count_next == '0) begin
                data_reg <= '0;
            end else if (push && (wr_ptr_reg == rd_ptr_next)) begin
                data_reg <= data_i;
            end else begin
                data_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign data_o       = data_reg;
    assign data_valid_o = !fifo_empty;
    assign count_o      = count_reg;
    assign full_o       = fifo_full;
    assign empty_o      = fifo_empty;
    assign tag_valid_o  = tag_pending_reg && fifo_empty;
    assign tag_o        = tag_reg;
    assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_ascon_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_ascon_out_buffer
//
// Bench for ascon_out_buffer. A queue-based reference model tracks the
// expected buffer contents, tag slot and overflow flag every cycle; a table of
// hand-derived vectors covers reset and the fill/drain sequence; short
// sequences cover overflow, wrap, tag release and clear/reset; then a random
// run is checked against the model.
// -----------------------------------------------------------------------------
module tb_ascon_out_buffer;

    localparam int NB = 64;
    localparam int D  = 4;
    localparam int TB = 128;
    localparam int CW = $clog2(D + 1);

    logic           clock_i = 1'b0;
    logic           resetb_i, clear_i, wr_en_i, data_ready_i;
    logic           tag_en_i, tag_ack_i;
    logic [NB-1:0]  data_i;
    logic [TB-1:0]  tag_i;
    logic           data_valid_o, tag_valid_o, full_o, empty_o, overflow_o;
    logic [NB-1:0]  data_o;
    logic [TB-1:0]  tag_o;
    logic [CW-1:0]  count_o;

    always #5 clock_i = ~clock_i;

    ascon_out_buffer #(
        .nb_bits_g (NB),
        .depth_g   (D),
        .tag_bits_g(TB)
    ) dut (
        .clock_i     (clock_i),
        .resetb_i    (resetb_i),
        .clear_i     (clear_i),
        .wr_en_i     (wr_en_i),
        .data_i      (data_i),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .data_o      (data_o),
        .tag_en_i    (tag_en_i),
        .tag_i       (tag_i),
        .tag_valid_o (tag_valid_o),
        .tag_ack_i   (tag_ack_i),
        .tag_o       (tag_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NB-1:0] mq[$];
    logic          m_pend = 1'b0;
    logic          m_ovf  = 1'b0;
    logic [TB-1:0] m_tag  = '0;

    task automatic chk(input string name, input logic [TB-1:0] act, input logic [TB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit was_empty, pop, tv, ack;
        if (!resetb_i || clear_i) begin
            mq.delete();
            m_pend = 1'b0;
            m_tag  = '0;
            m_ovf  = 1'b0;
        end else begin
            was_empty = (mq.size() == 0);
            pop       = !was_empty && data_ready_i;
            tv        = m_pend && was_empty;
            ack       = tag_ack_i && tv;
            if (wr_en_i && mq.size() == D && !pop) m_ovf = 1'b1;
            if (pop) void'(mq.pop_front());
            if (wr_en_i && mq.size() < D) mq.push_back(data_i);
            if (tag_en_i) begin
                if (m_pend && !ack) m_ovf = 1'b1;
                m_tag  = tag_i;
                m_pend = 1'b1;
            end else if (ack) begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string nm);
        int n;
        logic [NB-1:0] head;
        n    = mq.size();
        head = (n != 0) ? mq[0] : '0;
        chk({nm, ":count"},     TB'(count_o),      TB'(n));
        chk({nm, ":empty"},     TB'(empty_o),      TB'(n == 0));
        chk({nm, ":full"},      TB'(full_o),       TB'(n == D));
        chk({nm, ":valid"},     TB'(data_valid_o), TB'(n != 0));
        chk({nm, ":data"},      TB'(data_o),       TB'(head));
        chk({nm, ":tag_valid"}, TB'(tag_valid_o),  TB'(m_pend && n == 0));
        chk({nm, ":tag"},       tag_o,             m_tag);
        chk({nm, ":overflow"},  TB'(overflow_o),   TB'(m_ovf));
    endtask

    task automatic step(input logic rstb, input logic clr, input logic wr, input logic [NB-1:0] d,
                        input logic rdy, input logic ten, input logic [TB-1:0] t, input logic tack,
                        input string nm);
        resetb_i     = rstb;
        clear_i      = clr;
        wr_en_i      = wr;
        data_i       = d;
        data_ready_i = rdy;
        tag_en_i     = ten;
        tag_i        = t;
        tag_ack_i    = tack;
        model_step();
        @(posedge clock_i);
        #1;
        compare_all(nm);
    endtask

    task automatic do_reset(input string nm);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, nm);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, nm);
    endtask

    typedef struct {
        logic          rstb;
        logic          wr;
        logic [NB-1:0] d;
        logic          rdy;
        int            exp_count;
        logic [NB-1:0] exp_data;
        logic          exp_tvalid;
        logic          exp_ovf;
    } vec_t;

    function automatic vec_t mk(input logic rstb, input logic wr, input logic [NB-1:0] d,
                                input logic rdy, input int ec, input logic [NB-1:0] ed,
                                input logic etv, input logic eov);
        vec_t v;
        v.rstb = rstb; v.wr = wr; v.d = d; v.rdy = rdy;
        v.exp_count = ec; v.exp_data = ed; v.exp_tvalid = etv; v.exp_ovf = eov;
        return v;
    endfunction

    vec_t tbl[11];

    localparam logic [TB-1:0] TAG_A5 = {16{8'hA5}};
    localparam logic [TB-1:0] TAG_T1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [TB-1:0] TAG_T2 = 128'h0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0;
    localparam logic [TB-1:0] TAG_T3 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;

    initial begin
        resetb_i = 1'b0; clear_i = 1'b0; wr_en_i = 1'b0; data_i = '0;
        data_ready_i = 1'b0; tag_en_i = 1'b0; tag_i = '0; tag_ack_i = 1'b0;

        // Reset, fill to full without draining, then drain in order.
        tbl[0]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 0, 64'h0,  1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 0, 64'h0,  1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 64'h11, 1'b0, 1, 64'h11, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 64'h22, 1'b0, 2, 64'h11, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 64'h33, 1'b0, 3, 64'h11, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b1, 64'h44, 1'b0, 4, 64'h11, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 3, 64'h22, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 2, 64'h33, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 1, 64'h44, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 0, 64'h0,  1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 64'h0,  1'b0, 0, 64'h0,  1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rstb, 1'b0, tbl[i].wr, tbl[i].d, tbl[i].rdy, 1'b0, '0, 1'b0, "tbl");
            $display("vec %0d: count=%0d data=%0h tag_valid=%0b overflow=%0b",
                     i, count_o, data_o, tag_valid_o, overflow_o);
            chk($sformatf("tbl%0d:count", i), TB'(count_o),     TB'(tbl[i].exp_count));
            chk($sformatf("tbl%0d:full", i),  TB'(full_o),      TB'(tbl[i].exp_count == D));
            chk($sformatf("tbl%0d:empty", i), TB'(empty_o),     TB'(tbl[i].exp_count == 0));
            chk($sformatf("tbl%0d:data", i),  TB'(data_o),      TB'(tbl[i].exp_data));
            chk($sformatf("tbl%0d:tv", i),    TB'(tag_valid_o), TB'(tbl[i].exp_tvalid));
            chk($sformatf("tbl%0d:ovf", i),   TB'(overflow_o),  TB'(tbl[i].exp_ovf));
        end

        // Overflow on a full FIFO, then simultaneous push/pop across the wrap.
        do_reset("s3_rst");
        for (int i = 1; i <= 4; i++)
            step(1'b1, 1'b0, 1'b1, 64'hA0 + 64'(i), 1'b0, 1'b0, '0, 1'b0, "s3_fill");
        step(1'b1, 1'b0, 1'b1, 64'h55, 1'b0, 1'b0, '0, 1'b0, "s3_drop");
        $display("s3 drop: count=%0d overflow=%0b", count_o, overflow_o);
        chk("s3_drop_ovf",   TB'(overflow_o), TB'(1));
        chk("s3_drop_count", TB'(count_o),    TB'(4));
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b1, 64'hB0 + 64'(i), 1'b1, 1'b0, '0, 1'b0, "s3_pushpop");
            $display("s3 push/pop %0d: count=%0d head=%0h", i, count_o, data_o);
            chk("s3_pushpop_count", TB'(count_o), TB'(4));
        end
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "s3_drain");

        // Tag waits for the frame's words to drain.
        do_reset("s4_rst");
        step(1'b1, 1'b0, 1'b1, 64'hC1, 1'b0, 1'b0, '0,     1'b0, "s4_push1");
        step(1'b1, 1'b0, 1'b1, 64'hC2, 1'b0, 1'b1, TAG_A5, 1'b0, "s4_push2_tag");
        chk("s4_tv_hidden0", TB'(tag_valid_o), TB'(0));
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, "s4_pop1");
        chk("s4_tv_hidden1", TB'(tag_valid_o), TB'(0));
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "s4_pop2");
        $display("s4 last pop: tag_valid=%0b tag=%0h", tag_valid_o, tag_o);
        chk("s4_tv_after_pop", TB'(tag_valid_o), TB'(1));
        chk("s4_tag_value",    tag_o,            TAG_A5);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, "s4_ack");
        chk("s4_tv_after_ack", TB'(tag_valid_o), TB'(0));
        chk("s4_tag_held",     tag_o,            TAG_A5);

        // Tag overwrite versus ack-and-reload in the same cycle.
        do_reset("s5_rst");
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, TAG_T1, 1'b0, "s5_tag1");
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, TAG_T2, 1'b0, "s5_tag2");
        $display("s5 overwrite: tag=%0h overflow=%0b", tag_o, overflow_o);
        chk("s5_ovw_tag", tag_o,           TAG_T2);
        chk("s5_ovw_ovf", TB'(overflow_o), TB'(1));
        do_reset("s5_rst2");
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, TAG_T1, 1'b0, "s5_tag1b");
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, TAG_T3, 1'b1, "s5_ack_reload");
        $display("s5 ack+reload: tag_valid=%0b tag=%0h overflow=%0b", tag_valid_o, tag_o, overflow_o);
        chk("s5_reload_tv",  TB'(tag_valid_o), TB'(1));
        chk("s5_reload_ovf", TB'(overflow_o),  TB'(0));
        chk("s5_reload_tag", tag_o,            TAG_T3);

        // Clear mid-frame (with a push and tag in the same cycle), then reset mid-drain.
        do_reset("s6_rst");
        for (int i = 1; i <= 3; i++)
            step(1'b1, 1'b0, 1'b1, 64'hD0 + 64'(i), 1'b0, (i == 3), TAG_T1, 1'b0, "s6_fill");
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, TAG_T2, 1'b0, "s6_ovw");
        step(1'b1, 1'b1, 1'b1, 64'hEE, 1'b0, 1'b1, TAG_T3, 1'b0, "s6_clear");
        $display("s6 clear: count=%0d tag_valid=%0b overflow=%0b", count_o, tag_valid_o, overflow_o);
        chk("s6_clr_count", TB'(count_o),     TB'(0));
        chk("s6_clr_tv",    TB'(tag_valid_o), TB'(0));
        chk("s6_clr_ovf",   TB'(overflow_o),  TB'(0));
        chk("s6_clr_tag",   tag_o,            TB'(0));
        for (int i = 1; i <= 3; i++)
            step(1'b1, 1'b0, 1'b1, 64'hF0 + 64'(i), 1'b0, 1'b0, '0, 1'b0, "s6_refill");
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "s6_drain");
        step(1'b0, 1'b0, 1'b1, 64'h99, 1'b1, 1'b0, '0, 1'b0, "s6_reset");
        $display("s6 reset: count=%0d data=%0h valid=%0b", count_o, data_o, data_valid_o);
        chk("s6_rst_count", TB'(count_o),      TB'(0));
        chk("s6_rst_data",  TB'(data_o),       TB'(0));
        chk("s6_rst_valid", TB'(data_valid_o), TB'(0));
        chk("s6_rst_empty", TB'(empty_o),      TB'(1));

        // Randomized traffic against the model.
        do_reset("rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
                 {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 1) == 1), "rnd");
        end
        $display("random phase done: count=%0d overflow=%0b", count_o, overflow_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
